// File: rtl/mem_lsu.sv
`default_nettype none
// =============================================================================
// Module   : mem_lsu
// Purpose  : Memory-access stage with req/ack data bus, lane steering and load
//            extension; stalls the pipeline while an access is outstanding.
// Revision : 1.0
// =============================================================================
module mem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ex_wd_i,
    input  logic        ex_wreg_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [3:0]  ex_mem_op_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_mem_sdata_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_wdata_o,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_ack_i,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic        stallreq_o,
    output logic        mem_align_err_o,
    output logic        mem_bus_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [1:0]  w_a;
    logic        w_is_load, w_is_store, w_is_byte, w_is_half, w_is_word;
    logic        w_misaligned;
    logic [3:0]  w_lane_sel;
    logic [31:0] w_lane_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_a        = ex_mem_addr_i[1:0];
    assign w_is_load  = (ex_mem_op_i >= OP_LB) && (ex_mem_op_i <= OP_LW);
    assign w_is_store = (ex_mem_op_i >= OP_SB) && (ex_mem_op_i <= OP_SW);
    assign w_is_byte  = (ex_mem_op_i == OP_LB) || (ex_mem_op_i == OP_LBU) || (ex_mem_op_i == OP_SB);
    assign w_is_half  = (ex_mem_op_i == OP_LH) || (ex_mem_op_i == OP_LHU) || (ex_mem_op_i == OP_SH);
    assign w_is_word  = (ex_mem_op_i == OP_LW) || (ex_mem_op_i == OP_SW);
    assign w_misaligned = (w_is_half && w_a[0]) || (w_is_word && (w_a != 2'b00));

    always_comb begin
        w_lane_sel   = 4'b1111;
        w_lane_wdata = ex_mem_sdata_i;
        if (w_is_byte) begin
            w_lane_sel   = 4'b0001 << w_a;
            w_lane_wdata = {4{ex_mem_sdata_i[7:0]}};
        end else if (w_is_half) begin
            w_lane_sel   = w_a[1] ? 4'b1100 : 4'b0011;
            w_lane_wdata = {2{ex_mem_sdata_i[15:0]}};
        end
    end

    // Inputs are still held during DONE, so the lane offset comes from ex_mem_addr.
    assign w_byte = buf_q[{w_a, 3'b000} +: 8];
    assign w_half = w_a[1] ? buf_q[31:16] : buf_q[15:0];

    always_comb begin
        case (ex_mem_op_i)
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'd0, w_byte};
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = buf_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            buf_q   <= 32'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        sel_d           = sel_q;
        wdata_d         = wdata_q;
        buf_d           = buf_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        mem_wd_o        = ex_wd_i;
        mem_wreg_o      = ex_wreg_i;
        mem_wdata_o     = ex_wdata_i;
        stallreq_o      = 1'b0;
        mem_align_err_o = 1'b0;
        mem_bus_err_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_is_load || w_is_store) begin
                    mem_wreg_o = 1'b0;
                    if (w_misaligned) begin
                        mem_align_err_o = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                        state_d    = REQ;
                        req_d      = 1'b1;
                        we_d       = w_is_store;
                        addr_d     = {ex_mem_addr_i[31:2], 2'b00};
                        sel_d      = w_lane_sel;
                        wdata_d    = w_lane_wdata;
                        cnt_d      = 8'd0;
                        err_d      = 1'b0;
                    end
                end
            end
            REQ: begin
                stallreq_o = 1'b1;
                mem_wreg_o = 1'b0;
                if (dbus_ack_i) begin
                    buf_d   = dbus_rdata_i;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d       = IDLE;
                err_d         = 1'b0;
                mem_bus_err_o = err_q;
                if (w_is_load && !err_q) begin
                    mem_wdata_o = w_load_data;
                end else begin
                    mem_wreg_o = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pipeline-facing outputs are forced quiet while reset is held.
        if (!rst_ni) begin
            mem_wd_o        = 5'd0;
            mem_wreg_o      = 1'b0;
            mem_wdata_o     = 32'd0;
            stallreq_o      = 1'b0;
            mem_align_err_o = 1'b0;
            mem_bus_err_o   = 1'b0;
        end
    end

    assign dbus_req_o   = req_q;
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_sel_o   = sel_q;
    assign dbus_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_lsu
// Purpose  : Directed self-checking bench for mem_lsu (TIMEOUT = 4).
// Revision : 1.0
// =============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_sdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq;
    logic        mem_align_err;
    logic        mem_bus_err;

    int checks   = 0;
    int failures = 0;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ex_wd_i         (ex_wd),
        .ex_wreg_i       (ex_wreg),
        .ex_wdata_i      (ex_wdata),
        .ex_mem_op_i     (ex_mem_op),
        .ex_mem_addr_i   (ex_mem_addr),
        .ex_mem_sdata_i  (ex_mem_sdata),
        .dbus_req_o      (dbus_req),
        .dbus_we_o       (dbus_we),
        .dbus_addr_o     (dbus_addr),
        .dbus_sel_o      (dbus_sel),
        .dbus_wdata_o    (dbus_wdata),
        .dbus_rdata_i    (dbus_rdata),
        .dbus_ack_i      (dbus_ack),
        .mem_wd_o        (mem_wd),
        .mem_wreg_o      (mem_wreg),
        .mem_wdata_o     (mem_wdata),
        .stallreq_o      (stallreq),
        .mem_align_err_o (mem_align_err),
        .mem_bus_err_o   (mem_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        e_wreg;
        logic        chk_data;
        logic        e_align;
    } vec_t;

    vec_t vecs[8];

    // Called at posedge+1 in IDLE; returns at posedge+2 of the following IDLE cycle.
    task automatic access(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int ack_at,
                          input logic [3:0] e_sel, input logic e_we, input logic [31:0] e_sw,
                          input logic [31:0] e_res, input logic e_wreg, input logic e_err,
                          input int e_req);
        int  reqc;
        int  stallc;
        bit  done;
        ex_mem_op    = op;
        ex_mem_addr  = addr;
        ex_mem_sdata = sdata;
        ex_wd        = 5'd7;
        ex_wreg      = 1'b1;
        ex_wdata     = 32'h5555_5555;
        #1;
        chk({name, " idle stall"}, {31'd0, stallreq}, 32'd1);
        chk({name, " idle wreg"}, {31'd0, mem_wreg}, 32'd0);
        stallc = stallreq ? 1 : 0;
        reqc   = 0;
        done   = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk);
            #1;
            dbus_ack = 1'b0;
            if (dbus_req) begin
                reqc++;
                if (stallreq) stallc++;
                chk({name, " addr"}, dbus_addr, {addr[31:2], 2'b00});
                chk({name, " sel"}, {28'd0, dbus_sel}, {28'd0, e_sel});
                chk({name, " we"}, {31'd0, dbus_we}, {31'd0, e_we});
                if (e_we) chk({name, " bus wdata"}, dbus_wdata, e_sw);
                chk({name, " req wreg"}, {31'd0, mem_wreg}, 32'd0);
                chk({name, " req buserr"}, {31'd0, mem_bus_err}, 32'd0);
                if (k == ack_at) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = rdata;
                end
            end else begin
                done = 1;
            end
        end
        if (!done) chk({name, " req never dropped"}, 32'd1, 32'd0);
        chk({name, " req cycles"}, reqc, e_req);
        chk({name, " stall cycles"}, stallc, e_req + 1);
        chk({name, " done stall"}, {31'd0, stallreq}, 32'd0);
        chk({name, " done wd"}, {27'd0, mem_wd}, 32'd7);
        chk({name, " done wreg"}, {31'd0, mem_wreg}, {31'd0, e_wreg});
        if (e_wreg) chk({name, " done wdata"}, mem_wdata, e_res);
        chk({name, " done buserr"}, {31'd0, mem_bus_err}, {31'd0, e_err});
        @(posedge clk);
        #1;
        ex_mem_op = 4'd0;
        ex_wreg   = 1'b0;
        #1;
        chk({name, " after stall"}, {31'd0, stallreq}, 32'd0);
        chk({name, " after buserr"}, {31'd0, mem_bus_err}, 32'd0);
        chk({name, " after req"}, {31'd0, dbus_req}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{op: 4'd0,  addr: 32'h0000_0000, wd: 5'd5,  wreg: 1'b1, wdata: 32'h1234_5678, e_wreg: 1'b1, chk_data: 1'b1, e_align: 1'b0};
        vecs[1] = '{op: 4'd7,  addr: 32'h0000_0001, wd: 5'd3,  wreg: 1'b1, wdata: 32'hDEAD_BEEF, e_wreg: 1'b1, chk_data: 1'b1, e_align: 1'b0};
        vecs[2] = '{op: 4'd15, addr: 32'h0000_0003, wd: 5'd31, wreg: 1'b0, wdata: 32'h0F0F_0F0F, e_wreg: 1'b0, chk_data: 1'b1, e_align: 1'b0};
        vecs[3] = '{op: 4'd5,  addr: 32'h0000_3001, wd: 5'd9,  wreg: 1'b1, wdata: 32'hAAAA_AAAA, e_wreg: 1'b0, chk_data: 1'b0, e_align: 1'b1};
        vecs[4] = '{op: 4'd3,  addr: 32'h0000_1001, wd: 5'd10, wreg: 1'b1, wdata: 32'h1111_1111, e_wreg: 1'b0, chk_data: 1'b0, e_align: 1'b1};
        vecs[5] = '{op: 4'd4,  addr: 32'h0000_1003, wd: 5'd11, wreg: 1'b1, wdata: 32'h2222_2222, e_wreg: 1'b0, chk_data: 1'b0, e_align: 1'b1};
        vecs[6] = '{op: 4'd10, addr: 32'h0000_2001, wd: 5'd12, wreg: 1'b1, wdata: 32'h3333_3333, e_wreg: 1'b0, chk_data: 1'b0, e_align: 1'b1};
        vecs[7] = '{op: 4'd11, addr: 32'h0000_2002, wd: 5'd13, wreg: 1'b1, wdata: 32'h4444_4444, e_wreg: 1'b0, chk_data: 1'b0, e_align: 1'b1};

        rst_n        = 1'b0;
        ex_wd        = 5'd5;
        ex_wreg      = 1'b1;
        ex_wdata     = 32'h1234_5678;
        ex_mem_op    = 4'd0;
        ex_mem_addr  = 32'd0;
        ex_mem_sdata = 32'd0;
        dbus_rdata   = 32'd0;
        dbus_ack     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst wd", {27'd0, mem_wd}, 32'd0);
        chk("rst wreg", {31'd0, mem_wreg}, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst stall", {31'd0, stallreq}, 32'd0);
        chk("rst req", {31'd0, dbus_req}, 32'd0);
        chk("rst sel", {28'd0, dbus_sel}, 32'd0);
        chk("rst addr", dbus_addr, 32'd0);
        ex_mem_op   = 4'd5;
        ex_mem_addr = 32'h0000_3001;
        #1;
        chk("rst align", {31'd0, mem_align_err}, 32'd0);
        chk("rst buserr", {31'd0, mem_bus_err}, 32'd0);
        ex_mem_op = 4'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ex_mem_op   = vecs[i].op;
            ex_mem_addr = vecs[i].addr;
            ex_wd       = vecs[i].wd;
            ex_wreg     = vecs[i].wreg;
            ex_wdata    = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d wd", i), {27'd0, mem_wd}, {27'd0, vecs[i].wd});
            chk($sformatf("vec%0d wreg", i), {31'd0, mem_wreg}, {31'd0, vecs[i].e_wreg});
            if (vecs[i].chk_data) chk($sformatf("vec%0d wdata", i), mem_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d stall", i), {31'd0, stallreq}, 32'd0);
            chk($sformatf("vec%0d align", i), {31'd0, mem_align_err}, {31'd0, vecs[i].e_align});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d no req", i), {31'd0, dbus_req}, 32'd0);
        end
        ex_mem_op = 4'd0;
        ex_wreg   = 1'b0;

        access("LB",  4'd1,  32'h0000_1003, 32'd0,         32'h80FF_0011, 0, 4'b1000, 1'b0, 32'd0,         32'hFFFF_FF80, 1'b1, 1'b0, 1);
        access("LBU", 4'd2,  32'h0000_1003, 32'd0,         32'h80FF_0011, 0, 4'b1000, 1'b0, 32'd0,         32'h0000_0080, 1'b1, 1'b0, 1);
        access("SH",  4'd10, 32'h0000_2002, 32'h0000_BEEF, 32'd0,         3, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'd0,         1'b0, 1'b0, 4);
        access("TO",  4'd5,  32'h0000_4000, 32'd0,         32'd0,        -1, 4'b1111, 1'b0, 32'd0,         32'd0,         1'b0, 1'b1, 4);
        access("LH",  4'd3,  32'h0000_1002, 32'd0,         32'h8001_7FFF, 1, 4'b1100, 1'b0, 32'd0,         32'hFFFF_8001, 1'b1, 1'b0, 2);
        access("LHU", 4'd4,  32'h0000_1000, 32'd0,         32'h8001_7FFF, 0, 4'b0011, 1'b0, 32'd0,         32'h0000_7FFF, 1'b1, 1'b0, 1);
        access("LW",  4'd5,  32'h0000_1004, 32'd0,         32'hCAFE_F00D, 2, 4'b1111, 1'b0, 32'd0,         32'hCAFE_F00D, 1'b1, 1'b0, 3);
        access("SB",  4'd9,  32'h0000_5001, 32'h1234_5678, 32'd0,         0, 4'b0010, 1'b1, 32'h7878_7878, 32'd0,         1'b0, 1'b0, 1);
        access("SW",  4'd11, 32'h0000_6000, 32'hA5A5_0F0F, 32'd0,         0, 4'b1111, 1'b1, 32'hA5A5_0F0F, 32'd0,         1'b0, 1'b0, 1);

        // Reset in the middle of an outstanding load, then a stray ack.
        ex_mem_op   = 4'd5;
        ex_mem_addr = 32'h0000_4008;
        ex_wd       = 5'd7;
        ex_wreg     = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst req before", {31'd0, dbus_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst req", {31'd0, dbus_req}, 32'd0);
        chk("midrst stall", {31'd0, stallreq}, 32'd0);
        chk("midrst wreg", {31'd0, mem_wreg}, 32'd0);
        chk("midrst wd", {27'd0, mem_wd}, 32'd0);
        @(posedge clk);
        #1;
        ex_mem_op = 4'd0;
        ex_wreg   = 1'b0;
        rst_n     = 1'b1;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
        chk("late ack wreg", {31'd0, mem_wreg}, 32'd0);
        chk("late ack stall", {31'd0, stallreq}, 32'd0);
        chk("late ack req", {31'd0, dbus_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("late ack idle wreg", {31'd0, mem_wreg}, 32'd0);

        access("LBU2", 4'd2, 32'h0000_7001, 32'd0, 32'h1234_AB56, 0, 4'b0010, 1'b0, 32'd0, 32'h0000_00AB, 1'b1, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the five-stage pipeline, between the EX/MEM register and `mem_wb`. It executes loads and stores over a req/ack data bus and stalls the pipeline while the bus is busy. It passes non-memory results through unchanged and returns byte, halfword or word load data, aligned and extended, on `mem_wd` / `mem_wreg` / `mem_wdata` for capture by `mem_wb`.

## Interface
- `TIMEOUT`, default 255: number of REQ cycles without `dbus_ack` before the access is abandoned (legal range 1–255).
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex_wd`  in  5  destination register address.
- `ex_wreg`  in  1  write-enable from EX.
- `ex_wdata`  in  32  ALU result; written back unchanged for non-memory ops.
- `ex_mem_op`  in  4  0=NOP, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 9=SB, 10=SH, 11=SW; every other code behaves as NOP.
- `ex_mem_addr`  in  32  effective byte address.
- `ex_mem_sdata`  in  32  store data (register value).
- `dbus_req`  out  1  registered bus request.
- `dbus_we`  out  1  registered; 1 = store.
- `dbus_addr`  out  32  registered; `{ex_mem_addr[31:2],2'b00}`.
- `dbus_sel`  out  4  registered byte-lane enables.
- `dbus_wdata`  out  32  registered, lane-replicated store data.
- `dbus_rdata`  in  32  read data; valid in the cycle `dbus_ack`=1.
- `dbus_ack`  in  1  single-cycle completion strobe.
- `mem_wd`  out  5  to `mem_wb`.
- `mem_wreg`  out  1  to `mem_wb`.
- `mem_wdata`  out  32  to `mem_wb`.
- `stallreq`  out  1  combinational stall request to pipeline control.
- `mem_align_err`  out  1  combinational misalignment flag.
- `mem_bus_err`  out  1  timeout flag, high for one cycle.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- Upstream holds all `ex_*` inputs stable in any cycle where `stallreq`=1.
- IDLE with NOP or unknown op:
  - `mem_wd`=`ex_wd`, `mem_wreg`=`ex_wreg`, `mem_wdata`=`ex_wdata`.
  - `stallreq`=0.
- IDLE with a misaligned op:
  - Misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - No bus access; `mem_align_err`=1, `mem_wreg`=0, `stallreq`=0; stay in IDLE.
- IDLE with an aligned memory op:
  - `stallreq`=1, `mem_wreg`=0.
  - Next edge: enter REQ and load the `dbus_*` registers.
  - `dbus_req`=1; `dbus_we`=1 for stores.
- Lanes (`a`=`addr[1:0]`):
  - SB: `sel`=`4'b0001<<a`, `wdata`=`{4{sdata[7:0]}}`.
  - SH: `sel`=`a[1]?4'b1100:4'b0011`, `wdata`=`{2{sdata[15:0]}}`.
  - SW: `sel`=`4'b1111`, `wdata`=`sdata`.
  - Loads use the same `sel` patterns.
- REQ:
  - `stallreq`=1, `mem_wreg`=0.
  - `dbus_*` held constant until ack.
  - On an edge where `dbus_ack`=1: latch `dbus_rdata` into the load buffer, clear `dbus_req`, enter DONE.
  - The timeout counter clears on REQ entry and increments on each REQ cycle without ack.
  - In the cycle the counter equals `TIMEOUT`-1 with no ack: next edge clears `dbus_req`, sets the error flag, enters DONE.
- DONE:
  - `stallreq`=0, `mem_wd`=`ex_wd`.
  - Loads: `mem_wreg`=`ex_wreg`; `mem_wdata` = extracted byte or halfword, sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - Byte extracted from `buf[8a+7:8a]`; halfword from `a[1]?buf[31:16]:buf[15:0]`.
  - Stores: `mem_wreg`=0.
  - On timeout: `mem_wreg`=0 and `mem_bus_err`=1.
  - Next edge: return to IDLE; `mem_wb` captures this instruction on that same edge.
- `mem_wreg` is 0 whenever `stallreq`=1.
- Stores never write back.
- `dbus_ack` is ignored in IDLE and DONE.

## Timing
- Non-memory op: zero added latency (combinational pass-through).
- Memory op with ack in the first REQ cycle: 3 cycles (IDLE, REQ, DONE) and 2 stall cycles.
- Each additional wait cycle adds one cycle.
- Timeout: `dbus_req` held exactly `TIMEOUT` cycles; `mem_bus_err` high in DONE only.
- Reset (asynchronous, any state, including mid-REQ):
  - State returns to IDLE; `dbus_req`/`we`/`sel`/`addr`/`wdata`=0; load buffer, counter and error flag cleared.
  - While `rst`=0: `mem_wd`=0, `mem_wreg`=0, `mem_wdata`=0, `stallreq`=0, both error flags 0.
  - An ack arriving after reset release in IDLE is ignored.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after DONE; no bubble is inserted by this block.

## Test plan
- Pass-through: op=0, `ex_wd`=5, `ex_wdata`=0x12345678, `ex_wreg`=1 -> same cycle `mem_wd`=5, `mem_wdata`=0x12345678, `mem_wreg`=1, `stallreq`=0.
- LB addr 0x1003, rdata 0x80FF0011, ack in first REQ -> `dbus_addr`=0x1000, `sel`=4'b1000, `stallreq` high 2 cycles; DONE `mem_wdata`=0xFFFFFF80. Same with LBU -> 0x00000080.
- SH addr 0x2002, sdata 0x0000BEEF, ack after 3 wait cycles -> `dbus_we`=1, `sel`=4'b1100, `wdata`=0xBEEFBEEF; `req` high 4 cycles; `mem_wreg`=0 throughout.
- LW addr 0x3001 -> `mem_align_err`=1, `dbus_req` never rises, `stallreq`=0, `mem_wreg`=0.
- `TIMEOUT`=4, LW with no ack -> `req` high exactly 4 cycles; DONE `mem_bus_err`=1, `mem_wreg`=0; then IDLE.
- Reset asserted during REQ -> `dbus_req`=0 immediately, state IDLE; a late ack after release produces no write-back.
